// File: rtl/alu_mc_pkg.sv
// Shared opcode indices and FSM state encoding for the multi-cycle ALU.
// The helper isolates the lowest set opcode bit so multi-hot ops resolve deterministically.
package alu_mc_pkg;

  localparam int OP_ADD  = 0;
  localparam int OP_SUB  = 1;
  localparam int OP_CMP  = 2;
  localparam int OP_MUL  = 3;
  localparam int OP_DIV  = 4;
  localparam int OP_MOD  = 5;
  localparam int OP_LSL  = 6;
  localparam int OP_LSR  = 7;
  localparam int OP_ASR  = 8;
  localparam int OP_OR   = 9;
  localparam int OP_AND  = 10;
  localparam int OP_NOT  = 11;
  localparam int OP_MOV  = 12;
  localparam int NUM_OPS = 13;

  typedef enum logic [1:0] {
    IDLE,
    MUL_WAIT,
    DIV_RUN,
    DIV_DONE
  } state_t;

  function automatic logic [NUM_OPS-1:0] lowest_set(
    input logic [NUM_OPS-1:0] v
  );
    return v & (~v + NUM_OPS'(1));
  endfunction

endpackage

// File: rtl/alu_mc_if.sv
// Issue/retire bundle between the EX stage and the multi-cycle ALU.
// master drives operands and flush; slave returns ready, result and flags.
interface alu_mc_if #(
  parameter int WIDTH = 32
);
  import alu_mc_pkg::*;

  logic               in_valid;
  logic               in_ready;
  logic [NUM_OPS-1:0] op_onehot;
  logic [WIDTH-1:0]   opnd_a;
  logic [WIDTH-1:0]   opnd_b;
  logic               flush;
  logic               out_valid;
  logic [WIDTH-1:0]   result;
  logic [1:0]         flags;
  logic               div_by_zero;

  modport master (
    output in_valid,
    output op_onehot,
    output opnd_a,
    output opnd_b,
    output flush,
    input  in_ready,
    input  out_valid,
    input  result,
    input  flags,
    input  div_by_zero
  );

  modport slave (
    input  in_valid,
    input  op_onehot,
    input  opnd_a,
    input  opnd_b,
    input  flush,
    output in_ready,
    output out_valid,
    output result,
    output flags,
    output div_by_zero
  );

endinterface

// File: rtl/alu_div_iter.sv
// Unsigned restoring radix-2 divider, one quotient bit per cycle.
// done marks the cycle whose edge retires the last iteration; quotient/remainder are that edge's values.
module alu_div_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_start,
  input  logic             i_abort,
  input  logic [WIDTH-1:0] i_dividend,
  input  logic [WIDTH-1:0] i_divisor,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_quotient,
  output logic [WIDTH-1:0] o_remainder
);

  localparam int CW = $clog2(WIDTH);

  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_dvs;
  logic [CW-1:0]    r_cnt;
  logic             r_busy;

  logic [WIDTH:0]   w_shift;
  logic [WIDTH:0]   w_diff;
  logic             w_fit;
  logic [WIDTH-1:0] w_rem_nx;
  logic [WIDTH-1:0] w_quo_nx;

  // Top bit of the (WIDTH+1)-bit difference is the borrow.
  assign w_shift  = {r_rem, r_quo[WIDTH-1]};
  assign w_diff   = w_shift - {1'b0, r_dvs};
  assign w_fit    = ~w_diff[WIDTH];
  assign w_rem_nx = w_fit ? w_diff[WIDTH-1:0]
                          : w_shift[WIDTH-1:0];
  assign w_quo_nx = {r_quo[WIDTH-2:0], w_fit};

  assign o_busy      = r_busy;
  assign o_done      = r_busy &
                       (r_cnt == CW'(WIDTH-1));
  assign o_quotient  = w_quo_nx;
  assign o_remainder = w_rem_nx;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rem  <= '0;
      r_quo  <= '0;
      r_dvs  <= '0;
      r_cnt  <= '0;
      r_busy <= 1'b0;
    end else if (i_abort) begin
      r_busy <= 1'b0;
    end else if (i_start) begin
      r_rem  <= '0;
      r_quo  <= i_dividend;
      r_dvs  <= i_divisor;
      r_cnt  <= '0;
      r_busy <= 1'b1;
    end else if (r_busy) begin
      r_rem <= w_rem_nx;
      r_quo <= w_quo_nx;
      r_cnt <= r_cnt + 1'b1;
      if (o_done)
        r_busy <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_mc_unit.sv
// Multi-cycle EX-stage ALU: registered single-cycle ops, pipelined multiply,
// iterative divide; one multi-cycle op in flight so results retire in order.
module alu_mc_unit
  import alu_mc_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int MUL_STAGES = 2
) (
  input  logic    clk,
  input  logic    reset,
  alu_mc_if.slave bus
);

  localparam int SHW = $clog2(WIDTH);
  localparam int MCW = 3;
  localparam int MP  = (MUL_STAGES > 1) ? MUL_STAGES - 1 : 1;

  state_t r_state;
  state_t w_state_nx;

  logic [MCW-1:0]   r_mul_cnt;
  logic [WIDTH-1:0] r_mul_pipe [MP];
  logic [WIDTH-1:0] r_result;
  logic [1:0]       r_flags;
  logic             r_out_valid;
  logic             r_dbz;
  logic             r_is_mod;

  logic [NUM_OPS-1:0] w_sel;
  logic               w_ready;
  logic               w_accept;
  logic               w_is_div;
  logic               w_b_zero;
  logic               w_div_start;
  logic               w_mul_start;
  logic               w_mul_last;
  logic [SHW-1:0]     w_shamt;
  logic [WIDTH-1:0]   w_prod;
  logic [WIDTH-1:0]   w_alu;
  logic [1:0]         w_flags_cmp;

  logic               w_div_busy;
  logic               w_div_done;
  logic [WIDTH-1:0]   w_div_quo;
  logic [WIDTH-1:0]   w_div_rem;

  logic               w_ov_nx;
  logic               w_res_we;
  logic [WIDTH-1:0]   w_res_nx;
  logic               w_flg_we;
  logic               w_dbz_nx;

  assign w_sel    = lowest_set(bus.op_onehot);
  assign w_ready  = (r_state == IDLE);
  assign w_accept = bus.in_valid & w_ready & ~bus.flush;
  assign w_is_div = w_sel[OP_DIV] | w_sel[OP_MOD];
  assign w_b_zero = (bus.opnd_b == '0);

  assign w_div_start = w_accept & w_is_div & ~w_b_zero;
  assign w_mul_start = w_accept & w_sel[OP_MUL] &
                       (MUL_STAGES > 1);
  assign w_mul_last  = (r_state == MUL_WAIT) &&
                       (r_mul_cnt == MCW'(MUL_STAGES-1));

  assign w_shamt     = bus.opnd_b[SHW-1:0];
  assign w_prod      = bus.opnd_a * bus.opnd_b;
  assign w_flags_cmp = {
    $signed(bus.opnd_a) > $signed(bus.opnd_b),
    bus.opnd_a == bus.opnd_b
  };

  // DIV/MOD arms only matter for a zero divisor.
  always_comb begin
    w_alu = '0;
    unique case (1'b1)
      w_sel[OP_ADD]: w_alu = bus.opnd_a + bus.opnd_b;
      w_sel[OP_SUB]: w_alu = bus.opnd_a - bus.opnd_b;
      w_sel[OP_CMP]: w_alu = bus.opnd_a - bus.opnd_b;
      w_sel[OP_MUL]: w_alu = w_prod;
      w_sel[OP_DIV]: w_alu = '1;
      w_sel[OP_MOD]: w_alu = bus.opnd_a;
      w_sel[OP_LSL]: w_alu = bus.opnd_a << w_shamt;
      w_sel[OP_LSR]: w_alu = bus.opnd_a >> w_shamt;
      w_sel[OP_ASR]:
        w_alu = $signed(bus.opnd_a) >>> w_shamt;
      w_sel[OP_OR]:  w_alu = bus.opnd_a | bus.opnd_b;
      w_sel[OP_AND]: w_alu = bus.opnd_a & bus.opnd_b;
      w_sel[OP_NOT]: w_alu = ~bus.opnd_a;
      w_sel[OP_MOV]: w_alu = bus.opnd_b;
      default:       w_alu = '0;
    endcase
  end

  alu_div_iter #(
    .WIDTH (WIDTH)
  ) u_div (
    .clk         (clk),
    .reset       (reset),
    .i_start     (w_div_start),
    .i_abort     (bus.flush),
    .i_dividend  (bus.opnd_a),
    .i_divisor   (bus.opnd_b),
    .o_busy      (w_div_busy),
    .o_done      (w_div_done),
    .o_quotient  (w_div_quo),
    .o_remainder (w_div_rem)
  );

  always_comb begin
    w_state_nx = r_state;
    w_ov_nx    = 1'b0;
    w_res_we   = 1'b0;
    w_res_nx   = w_alu;
    w_flg_we   = 1'b0;
    w_dbz_nx   = r_dbz;
    if (bus.flush) begin
      w_state_nx = IDLE;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_mul_start) begin
            w_state_nx = MUL_WAIT;
          end else if (w_div_start) begin
            w_state_nx = DIV_RUN;
          end else if (w_accept) begin
            w_ov_nx  = 1'b1;
            w_res_we = 1'b1;
            w_flg_we = w_sel[OP_CMP];
            w_dbz_nx = w_is_div;
          end
        end
        MUL_WAIT: begin
          if (w_mul_last) begin
            w_state_nx = IDLE;
            w_ov_nx    = 1'b1;
            w_res_we   = 1'b1;
            w_res_nx   = r_mul_pipe[MP-1];
            w_dbz_nx   = 1'b0;
          end
        end
        DIV_RUN: begin
          if (w_div_done) begin
            w_state_nx = DIV_DONE;
            w_ov_nx    = 1'b1;
            w_res_we   = 1'b1;
            w_res_nx   = r_is_mod ? w_div_rem
                                  : w_div_quo;
            w_dbz_nx   = 1'b0;
          end else if (!w_div_busy) begin
            w_state_nx = IDLE;
          end
        end
        DIV_DONE: w_state_nx = IDLE;
        default:  w_state_nx = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_mul_cnt   <= '0;
      r_result    <= '0;
      r_flags     <= 2'b00;
      r_out_valid <= 1'b0;
      r_dbz       <= 1'b0;
      r_is_mod    <= 1'b0;
    end else begin
      r_state     <= w_state_nx;
      r_out_valid <= w_ov_nx;
      r_dbz       <= w_dbz_nx;
      // Count starts at 1 so exit at MUL_STAGES-1 gives latency MUL_STAGES.
      if (r_state != MUL_WAIT)
        r_mul_cnt <= MCW'(1);
      else
        r_mul_cnt <= r_mul_cnt + 1'b1;
      if (w_res_we)
        r_result <= w_res_nx;
      if (w_flg_we)
        r_flags <= w_flags_cmp;
      if (w_div_start)
        r_is_mod <= w_sel[OP_MOD];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < MP; i++)
        r_mul_pipe[i] <= '0;
    end else begin
      r_mul_pipe[0] <= w_prod;
      for (int i = 1; i < MP; i++)
        r_mul_pipe[i] <= r_mul_pipe[i-1];
    end
  end

  assign bus.in_ready    = w_ready;
  assign bus.out_valid   = r_out_valid;
  assign bus.result      = r_result;
  assign bus.flags       = r_flags;
  assign bus.div_by_zero = r_dbz;

endmodule

// File: tb/tb_alu_mc_unit.sv
// Directed bench for alu_mc_unit with a result scoreboard.
// Inputs change and outputs are sampled on the falling edge.
module tb_alu_mc_unit;
  import alu_mc_pkg::*;

  localparam int W  = 32;
  localparam int MS = 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  alu_mc_if #(.WIDTH(W)) bus ();

  alu_mc_unit #(
    .WIDTH      (W),
    .MUL_STAGES (MS)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_assert = 0;
  int n_fail   = 0;

  logic [W-1:0] q_res [$];
  logic [1:0]   q_flg [$];
  logic         q_dbz [$];
  logic [1:0]   m_flags;
  logic [W-1:0] m_last;

  function automatic logic [12:0] oh(input int i);
    logic [12:0] v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  task automatic chk(input string tag,
                     input logic [W-1:0] obs,
                     input logic [W-1:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v,
                       input logic [12:0] op,
                       input logic [W-1:0] a,
                       input logic [W-1:0] b);
    bus.in_valid  = v;
    bus.op_onehot = op;
    bus.opnd_a    = a;
    bus.opnd_b    = b;
  endtask

  task automatic quiet(input string tag, input int n);
    int hits;
    hits = 0;
    repeat (n) begin
      @(negedge clk);
      if (bus.out_valid !== 1'b0) hits++;
    end
    chk(tag, W'(hits), 0);
  endtask

  task automatic run_op(input string tag,
                        input logic [12:0] op,
                        input logic [W-1:0] a,
                        input logic [W-1:0] b,
                        input logic [W-1:0] er,
                        input logic [1:0] ef,
                        input logic ed,
                        input int lat);
    int n;
    chk({tag, ".rdy"}, W'(bus.in_ready), 1);
    drive(1'b1, op, a, b);
    q_res.push_back(er);
    q_flg.push_back(ef);
    q_dbz.push_back(ed);
    @(negedge clk);
    drive(1'b0, '0, '0, '0);
    n = 1;
    while (bus.out_valid !== 1'b1 && n < 100) begin
      chk({tag, ".busy"}, W'(bus.in_ready), 0);
      @(negedge clk);
      n++;
    end
    chk({tag, ".lat"}, W'(n), W'(lat));
    if (bus.out_valid === 1'b1 && q_res.size() > 0) begin
      chk({tag, ".res"}, bus.result, q_res.pop_front());
      chk({tag, ".flg"}, W'(bus.flags),
          W'(q_flg.pop_front()));
      chk({tag, ".dbz"}, W'(bus.div_by_zero),
          W'(q_dbz.pop_front()));
      m_last = er;
    end else begin
      q_res.delete();
      q_flg.delete();
      q_dbz.delete();
    end
    @(negedge clk);
    chk({tag, ".pulse"}, W'(bus.out_valid), 0);
  endtask

  initial begin
    reset     = 1'b1;
    bus.flush = 1'b0;
    drive(1'b0, '0, '0, '0);
    m_flags = 2'b00;
    m_last  = '0;
    repeat (2) @(negedge clk);
    chk("rst.rdy", W'(bus.in_ready), 1);
    chk("rst.ov",  W'(bus.out_valid), 0);
    chk("rst.res", bus.result, 0);
    chk("rst.flg", W'(bus.flags), 0);
    chk("rst.dbz", W'(bus.div_by_zero), 0);
    reset = 1'b0;
    @(negedge clk);

    m_flags = 2'b01;
    run_op("cmp0", oh(OP_CMP), 7, 7, 0, m_flags, 0, 1);

    // Reset lands in the middle of a long divide.
    drive(1'b1, oh(OP_DIV), 100, 7);
    @(negedge clk);
    drive(1'b0, '0, '0, '0);
    repeat (8) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("rdiv.rdy", W'(bus.in_ready), 1);
    chk("rdiv.ov",  W'(bus.out_valid), 0);
    chk("rdiv.flg", W'(bus.flags), 0);
    chk("rdiv.res", bus.result, 0);
    m_flags = 2'b00;
    m_last  = '0;
    quiet("rdiv.quiet", 40);

    run_op("add_wrap", oh(OP_ADD), 32'hFFFF_FFFF, 1,
           0, m_flags, 0, 1);
    run_op("lsl", oh(OP_LSL), 1, 33, 2, m_flags, 0, 1);
    run_op("lsr", oh(OP_LSR), 32'h8000_0000, 4,
           32'h0800_0000, m_flags, 0, 1);
    run_op("asr", oh(OP_ASR), 32'h8000_0000, 36,
           32'hF800_0000, m_flags, 0, 1);
    run_op("sub", oh(OP_SUB), 5, 7,
           32'hFFFF_FFFE, m_flags, 0, 1);
    run_op("or",  oh(OP_OR), 32'hF0, 32'h0F,
           32'hFF, m_flags, 0, 1);
    run_op("and", oh(OP_AND), 32'hFF00, 32'h0FF0,
           32'h0F00, m_flags, 0, 1);
    run_op("not", oh(OP_NOT), 32'h0F0F_0F0F, 32'h1234,
           32'hF0F0_F0F0, m_flags, 0, 1);
    run_op("mov", oh(OP_MOV), 1, 32'hCAFE,
           32'hCAFE, m_flags, 0, 1);
    run_op("multi", oh(OP_ADD) | oh(OP_SUB), 3, 4,
           7, m_flags, 0, 1);
    run_op("zero_hot", '0, 5, 6, 0, m_flags, 0, 1);

    m_flags = 2'b00;
    run_op("cmp_lt", oh(OP_CMP), -5, 3,
           32'hFFFF_FFF8, m_flags, 0, 1);
    m_flags = 2'b01;
    run_op("cmp_eq", oh(OP_CMP), 7, 7, 0, m_flags, 0, 1);
    m_flags = 2'b10;
    run_op("cmp_gt", oh(OP_CMP), 3, -5, 8, m_flags, 0, 1);
    run_op("add_hold", oh(OP_ADD), 1, 1, 2, m_flags, 0, 1);

    run_op("mul", oh(OP_MUL), 12345, 678,
           8369910, m_flags, 0, MS);
    run_op("mul_wrap", oh(OP_MUL), 32'hFFFF_FFFF,
           32'hFFFF_FFFF, 1, m_flags, 0, MS);
    run_op("mul_ovf", oh(OP_MUL), 32'h1_0000, 32'h1_0000,
           0, m_flags, 0, MS);

    run_op("div", oh(OP_DIV), 100, 7, 14, m_flags, 0, W+1);
    run_op("mod", oh(OP_MOD), 100, 7, 2, m_flags, 0, W+1);
    run_op("div0", oh(OP_DIV), 9, 0,
           32'hFFFF_FFFF, m_flags, 1, 1);
    run_op("mod0", oh(OP_MOD), 9, 0, 9, m_flags, 1, 1);
    run_op("dbz_clr", oh(OP_ADD), 2, 3, 5, m_flags, 0, 1);
    run_op("div_big", oh(OP_DIV), 32'hDEAD_BEEF, 16,
           32'h0DEA_DBEE, m_flags, 0, W+1);
    run_op("mod_big", oh(OP_MOD), 32'hDEAD_BEEF, 16,
           32'hF, m_flags, 0, W+1);
    run_op("div_small", oh(OP_DIV), 5, 9, 0, m_flags, 0, W+1);
    run_op("mod_small", oh(OP_MOD), 5, 9, 5, m_flags, 0, W+1);
    run_op("div_max", oh(OP_DIV), 32'hFFFF_FFFF,
           32'hFFFF_FFFF, 1, m_flags, 0, W+1);

    // Flush mid-divide with a competing op on the same cycle.
    drive(1'b1, oh(OP_DIV), 100, 7);
    @(negedge clk);
    drive(1'b0, '0, '0, '0);
    repeat (4) @(negedge clk);
    bus.flush = 1'b1;
    drive(1'b1, oh(OP_ADD), 1, 2);
    @(negedge clk);
    bus.flush = 1'b0;
    drive(1'b0, '0, '0, '0);
    chk("fdiv.rdy", W'(bus.in_ready), 1);
    chk("fdiv.ov",  W'(bus.out_valid), 0);
    chk("fdiv.res", bus.result, m_last);
    chk("fdiv.flg", W'(bus.flags), W'(m_flags));
    run_op("fdiv.add", oh(OP_ADD), 10, 20,
           30, m_flags, 0, 1);
    quiet("fdiv.quiet", 40);

    // Flush on the cycle the multiply would retire.
    drive(1'b1, oh(OP_MUL), 3, 4);
    @(negedge clk);
    drive(1'b0, '0, '0, '0);
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    chk("fmul.rdy", W'(bus.in_ready), 1);
    chk("fmul.ov",  W'(bus.out_valid), 0);
    chk("fmul.res", bus.result, m_last);
    quiet("fmul.quiet", 10);
    run_op("after", oh(OP_MUL), 6, 7, 42, m_flags, 0, MS);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
